// File: rtl/div_issue_ctrl.sv
// EX-stage sequencer for the shared iterative divider: launches div/mod ops,
// selects quotient or remainder, stalls EX until done and reuses a one-entry result cache.
module div_issue_ctrl #(
  parameter int WIDTH    = 32,
  parameter bit CACHE_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             req_valid,
  input  logic [1:0]       req_op,
  input  logic [WIDTH-1:0] src1,
  input  logic [WIDTH-1:0] src2,
  input  logic             flush,
  output logic             stall,
  output logic             res_valid,
  output logic [WIDTH-1:0] result,
  output logic             div_en,
  output logic [WIDTH-1:0] div_dividend,
  output logic [WIDTH-1:0] div_divisor,
  output logic             div_sign,
  output logic             div_flush,
  input  logic [WIDTH-1:0] div_quotient,
  input  logic [WIDTH-1:0] div_remainder,
  input  logic             div_ready,
  input  logic             div_busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t           state;
  logic             op_rem;
  logic             done_q;
  logic             cache_vld;
  logic             cache_sign;
  logic [WIDTH-1:0] cache_src1;
  logic [WIDTH-1:0] cache_src2;
  logic [WIDTH-1:0] cache_q;
  logic [WIDTH-1:0] cache_r;
  logic             req_sign;
  logic             div_zero;
  logic             cache_hit;

  function automatic logic [WIDTH-1:0] sel_result(input logic             rem,
                                                  input logic [WIDTH-1:0] q,
                                                  input logic [WIDTH-1:0] r);
    return rem ? r : q;
  endfunction

  assign req_sign  = ~req_op[1];
  assign div_zero  = (src2 == '0);
  assign cache_hit = CACHE_EN && cache_vld && (cache_src1 == src1) &&
                     (cache_src2 == src2) && (cache_sign == req_sign);

  // A flush kills the strobe even in DONE, so the killed result never reaches EX.
  assign res_valid = done_q & ~flush;
  assign stall     = req_valid & ~res_valid;
  // The divider shares rstn, so reset alone never raises the abort.
  assign div_flush = flush & rstn;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state        <= IDLE;
      done_q       <= 1'b0;
      div_en       <= 1'b0;
      result       <= '0;
      div_dividend <= '0;
      div_divisor  <= '0;
      div_sign     <= 1'b0;
      op_rem       <= 1'b0;
      cache_vld    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      div_en <= 1'b0;
      if (flush) begin
        state <= IDLE;
      end else begin
        case (state)
          IDLE: begin
            if (req_valid) begin
              div_dividend <= src1;
              div_divisor  <= src2;
              div_sign     <= req_sign;
              op_rem       <= req_op[0];
              if (div_zero) begin
                result <= sel_result(req_op[0], '1, src1);
                done_q <= 1'b1;
                state  <= DONE;
              end else if (cache_hit) begin
                result <= sel_result(req_op[0], cache_q, cache_r);
                done_q <= 1'b1;
                state  <= DONE;
              end else begin
                state <= ISSUE;
              end
            end
          end
          ISSUE: begin
            if (!div_busy) begin
              div_en <= 1'b1;
              state  <= WAIT;
            end
          end
          WAIT: begin
            if (div_ready) begin
              result     <= sel_result(op_rem, div_quotient, div_remainder);
              cache_vld  <= 1'b1;
              cache_src1 <= div_dividend;
              cache_src2 <= div_divisor;
              cache_sign <= div_sign;
              cache_q    <= div_quotient;
              cache_r    <= div_remainder;
              done_q     <= 1'b1;
              state      <= DONE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_div_issue_ctrl.sv
// Directed bench for div_issue_ctrl: arithmetic reference model, a per-cycle
// compare process, a behavioural fixed-latency divider, and literal expectations.
module tb_div_issue_ctrl;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        req_valid = 1'b0;
  logic [1:0]  req_op = 2'b00;
  logic [31:0] src1 = '0;
  logic [31:0] src2 = '0;
  logic        flush = 1'b0;
  logic        stall;
  logic        res_valid;
  logic [31:0] result;
  logic        div_en;
  logic [31:0] div_dividend;
  logic [31:0] div_divisor;
  logic        div_sign;
  logic        div_flush;
  logic [31:0] div_quotient;
  logic [31:0] div_remainder;
  logic        div_ready;
  logic        div_busy = 1'b0;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  div_issue_ctrl #(.WIDTH(32), .CACHE_EN(1'b1)) dut (
    .clk(clk), .rstn(rstn), .req_valid(req_valid), .req_op(req_op),
    .src1(src1), .src2(src2), .flush(flush), .stall(stall),
    .res_valid(res_valid), .result(result), .div_en(div_en),
    .div_dividend(div_dividend), .div_divisor(div_divisor), .div_sign(div_sign),
    .div_flush(div_flush), .div_quotient(div_quotient), .div_remainder(div_remainder),
    .div_ready(div_ready), .div_busy(div_busy)
  );

  // Architectural result of a RISC-V M-extension 32-bit divide/remainder.
  function automatic logic [31:0] spec_result(input logic [1:0] op, input logic [31:0] a,
                                              input logic [31:0] b);
    logic signed [31:0] sa;
    logic signed [31:0] sb;
    logic signed [31:0] sr;
    if (b == 32'd0) return op[0] ? a : 32'hFFFF_FFFF;
    if (!op[1]) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return op[0] ? 32'd0 : 32'h8000_0000;
      sa = a;
      sb = b;
      sr = op[0] ? (sa % sb) : (sa / sb);
      return sr;
    end
    return op[0] ? (a % b) : (a / b);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural divider: ready pulses dlat cycles after the start pulse is sampled.
  int          dlat = 1;
  int          dcnt = 0;
  logic [31:0] d_a = '0;
  logic [31:0] d_b = '0;
  logic        d_s = 1'b0;

  always @(posedge clk) begin
    if (!rstn || div_flush) dcnt <= 0;
    else if (div_en) begin
      dcnt <= dlat;
      d_a  <= div_dividend;
      d_b  <= div_divisor;
      d_s  <= div_sign;
    end else if (dcnt > 0) dcnt <= dcnt - 1;
  end

  always_comb begin
    div_ready     = (dcnt == 1);
    div_quotient  = spec_result({~d_s, 1'b0}, d_a, d_b);
    div_remainder = spec_result({~d_s, 1'b1}, d_a, d_b);
  end

  // Reference model, advanced once per cycle from the inputs visible in that cycle.
  logic        m_rv_next = 1'b0;
  logic        m_en_next = 1'b0;
  logic [31:0] m_hold = '0;
  logic        m_need_launch = 1'b0;
  logic        m_in_div = 1'b0;
  logic        m_result_cycle = 1'b0;
  logic [31:0] m_a = '0;
  logic [31:0] m_b = '0;
  logic        m_s = 1'b0;
  logic [31:0] m_exp = '0;
  logic        mc_vld = 1'b0;
  logic [31:0] mc_a = '0;
  logic [31:0] mc_b = '0;
  logic        mc_s = 1'b0;

  always @(negedge clk) begin
    if (!rstn) begin
      m_rv_next = 1'b0; m_en_next = 1'b0; m_hold = '0;
      m_need_launch = 1'b0; m_in_div = 1'b0; m_result_cycle = 1'b0; mc_vld = 1'b0;
    end else begin
      chk("stall", stall, req_valid & ~res_valid);
      chk("div_flush", div_flush, flush);
      chk("res_valid", res_valid, m_rv_next & ~flush);
      chk("div_en", div_en, m_en_next);
      chk("result_hold", result, m_hold);
      if (m_en_next) begin
        chk("div_dividend", div_dividend, m_a);
        chk("div_divisor", div_divisor, m_b);
        chk("div_sign", div_sign, m_s);
      end
      m_rv_next = 1'b0;
      m_en_next = 1'b0;
      if (flush) begin
        m_need_launch = 1'b0; m_in_div = 1'b0; m_result_cycle = 1'b0;
      end else if (m_result_cycle) begin
        m_result_cycle = 1'b0;
      end else if (m_need_launch) begin
        if (!div_busy) begin
          m_en_next = 1'b1; m_need_launch = 1'b0; m_in_div = 1'b1;
        end
      end else if (m_in_div) begin
        if (div_ready) begin
          m_rv_next = 1'b1; m_hold = m_exp; m_in_div = 1'b0; m_result_cycle = 1'b1;
          mc_vld = 1'b1; mc_a = m_a; mc_b = m_b; mc_s = m_s;
        end
      end else if (req_valid) begin
        m_a = src1; m_b = src2; m_s = ~req_op[1];
        m_exp = spec_result(req_op, src1, src2);
        if (src2 == 32'd0 || (mc_vld && mc_a == src1 && mc_b == src2 && mc_s == ~req_op[1])) begin
          m_rv_next = 1'b1; m_hold = m_exp; m_result_cycle = 1'b1;
        end else begin
          m_need_launch = 1'b1;
        end
      end
    end
  end

  // Present one op, hold it until the result strobe, check literal result,
  // number of divider launches and accept-to-strobe latency (skipped if exp_lat < 0).
  task automatic run_op(input string nm, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] lit, input int exp_en,
                        input int exp_lat);
    int   cyc;
    int   en;
    logic got;
    cyc = 0; en = 0; got = 1'b0;
    @(posedge clk); #1;
    req_valid = 1'b1; req_op = op; src1 = a; src2 = b;
    while (!got && cyc < 200) begin
      @(negedge clk);
      if (div_en) en++;
      if (res_valid) begin
        got = 1'b1;
        chk({nm, "_result"}, result, lit);
      end else cyc++;
    end
    chk({nm, "_done"}, got, 1'b1);
    chk({nm, "_launches"}, en, exp_en);
    if (exp_lat >= 0) chk({nm, "_latency"}, cyc, exp_lat);
  endtask

  task automatic idle(input int n);
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (n - 1) @(posedge clk);
  endtask

  task automatic wait_div_en(input string nm);
    int   cyc;
    logic seen;
    cyc = 0; seen = 1'b0;
    while (!seen && cyc < 20) begin
      @(negedge clk);
      if (div_en) seen = 1'b1;
      cyc++;
    end
    chk({nm, "_launch_seen"}, seen, 1'b1);
  endtask

  // Start a miss and flush it, either mid-wait or in the cycle div_ready arrives.
  task automatic flush_op(input string nm, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic at_ready);
    int rv;
    rv = 0;
    @(posedge clk); #1;
    req_valid = 1'b1; req_op = op; src1 = a; src2 = b;
    wait_div_en(nm);
    if (at_ready) begin
      repeat (dlat) @(posedge clk);
      #1;
    end else begin
      repeat (2) @(posedge clk);
      #1;
    end
    flush = 1'b1;
    @(negedge clk);
    if (at_ready) chk({nm, "_ready_align"}, div_ready, 1'b1);
    chk({nm, "_div_flush"}, div_flush, 1'b1);
    chk({nm, "_rv_in_flush"}, res_valid, 1'b0);
    @(posedge clk); #1;
    flush = 1'b0; req_valid = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (res_valid) rv++;
    end
    chk({nm, "_no_rv_after"}, rv, 0);
  endtask

  initial begin
    int cnt;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_result", result, 32'd0);
    chk("rst_res_valid", res_valid, 1'b0);
    chk("rst_div_en", div_en, 1'b0);
    chk("rst_div_flush", div_flush, 1'b0);
    chk("rst_stall", stall, 1'b0);
    @(posedge clk); #1;
    rstn = 1'b1;

    dlat = 1;
    run_op("t1_divu_9_3", 2'b10, 32'd9, 32'd3, 32'd3, 1, 4);
    run_op("t2_modu_hit", 2'b11, 32'd9, 32'd3, 32'd0, 0, 1);

    dlat = 3;
    run_op("t3_div_neg", 2'b00, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 1, 6);
    run_op("t3_mod_hit", 2'b01, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 0, 1);

    run_op("t4_divu_zero", 2'b10, 32'd5, 32'd0, 32'hFFFF_FFFF, 0, 1);
    run_op("t4_modu_zero", 2'b11, 32'd5, 32'd0, 32'd5, 0, 1);
    run_op("t4_cache_kept", 2'b00, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 0, 1);

    dlat = 2;
    run_op("ovf_div", 2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, 5);
    run_op("ovf_mod_hit", 2'b01, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 0, 1);

    idle(1);
    div_busy = 1'b1;
    fork
      run_op("busy_divu", 2'b10, 32'd1000, 32'd10, 32'd100, 1, -1);
      begin
        repeat (5) @(posedge clk);
        #1;
        div_busy = 1'b0;
      end
    join

    dlat = 8;
    flush_op("t5a", 2'b10, 32'd50, 32'd5, 1'b0);
    run_op("t5a_old_hit", 2'b10, 32'd1000, 32'd10, 32'd100, 0, 1);
    run_op("t5a_relaunch", 2'b10, 32'd50, 32'd5, 32'd10, 1, 11);
    flush_op("t5b", 2'b11, 32'd77, 32'd6, 1'b1);
    run_op("t5b_relaunch", 2'b11, 32'd77, 32'd6, 32'd5, 1, 11);

    // Flush coinciding with a request in IDLE must not accept it.
    @(posedge clk); #1;
    req_valid = 1'b1; req_op = 2'b10; src1 = 32'd20; src2 = 32'd4; flush = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0; flush = 1'b0;
    cnt = 0;
    repeat (6) begin
      @(negedge clk);
      if (div_en || res_valid) cnt++;
    end
    chk("idle_flush_no_accept", cnt, 0);

    // Flush in the strobe cycle of a cache hit.
    @(posedge clk); #1;
    req_valid = 1'b1; req_op = 2'b11; src1 = 32'd77; src2 = 32'd6;
    @(posedge clk); #1;
    flush = 1'b1;
    @(negedge clk);
    chk("done_flush_rv", res_valid, 1'b0);
    @(posedge clk); #1;
    flush = 1'b0; req_valid = 1'b0;
    repeat (2) @(posedge clk);

    @(posedge clk); #1;
    req_valid = 1'b1; req_op = 2'b10; src1 = 32'd300; src2 = 32'd9;
    wait_div_en("t6");
    @(posedge clk); #1;
    rstn = 1'b0;
    @(posedge clk); #1;
    rstn = 1'b1; req_valid = 1'b0;
    @(negedge clk);
    chk("t6_res_valid", res_valid, 1'b0);
    chk("t6_result", result, 32'd0);
    chk("t6_div_en", div_en, 1'b0);
    chk("t6_div_flush", div_flush, 1'b0);
    chk("t6_dividend", div_dividend, 32'd0);
    chk("t6_divisor", div_divisor, 32'd0);
    chk("t6_sign", div_sign, 1'b0);
    chk("t6_stall", stall, 1'b0);
    run_op("t6_divu_100_7", 2'b10, 32'd100, 32'd7, 32'd14, 1, 11);
    run_op("sign_key_miss", 2'b00, 32'd100, 32'd7, 32'd14, 1, 11);
    run_op("signed_mod_hit", 2'b01, 32'd100, 32'd7, 32'd2, 0, 1);
    idle(3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
